// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronised RX, centre-sampled 8-bit frames with optional parity,
// one-entry holding register with VALID/READ handshake and sticky overrun.
module uart_rx #(
    parameter int BIT_TIME = 40
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       RX,
    input  logic       PARITY_EN,
    input  logic       PARITY_ODD,
    input  logic       READ,
    output logic [7:0] DATA,
    output logic       VALID,
    output logic       PARITY_ERR,
    output logic       FRAME_ERR,
    output logic       OVERRUN,
    output logic       BUSY
);

    localparam int CNT_W = $clog2(BIT_TIME + 1);
    localparam logic [CNT_W-1:0] CNT_END = CNT_W'(BIT_TIME);
    localparam logic [CNT_W-1:0] CNT_MID = CNT_W'(BIT_TIME / 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t           state_q, state_d;
    logic             rx_meta_q, rxs_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             par_en_q, par_en_d;
    logic             par_acc_q, par_acc_d;
    logic             par_err_q, par_err_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             perr_q, perr_d;
    logic             ferr_q, ferr_d;
    logic             ovr_q, ovr_d;
    logic             deliver;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        par_en_d  = par_en_q;
        par_acc_d = par_acc_q;
        par_err_d = par_err_q;
        deliver   = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rxs_q) begin
                    state_d   = S_START;
                    bit_idx_d = '0;
                    par_en_d  = PARITY_EN;
                    par_acc_d = PARITY_ODD;
                    par_err_d = 1'b0;
                end
            end
            S_START: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_MID) begin
                    cnt_d   = '0;
                    state_d = rxs_q ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_END) begin
                    cnt_d     = '0;
                    shift_d   = {rxs_q, shift_q[7:1]};
                    par_acc_d = par_acc_q ^ rxs_q;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = par_en_q ? S_PARITY : S_STOP;
                    end
                end
            end
            S_PARITY: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_END) begin
                    cnt_d     = '0;
                    par_err_d = par_acc_q ^ rxs_q;
                    state_d   = S_STOP;
                end
            end
            S_STOP: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_END) begin
                    cnt_d   = '0;
                    deliver = 1'b1;
                    // A low stop bit may be a break; wait for the line to recover before re-arming.
                    state_d = rxs_q ? S_IDLE : S_WAIT_HIGH;
                end
            end
            S_WAIT_HIGH: begin
                cnt_d = '0;
                if (rxs_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Holding register: a delivery in the same cycle as READ keeps the new byte valid.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        ovr_d   = ovr_q;
        if (READ && valid_q) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end
        if (deliver) begin
            data_d  = shift_q;
            perr_d  = par_err_q;
            ferr_d  = ~rxs_q;
            valid_d = 1'b1;
            if (valid_q && !READ) begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            par_en_q  <= 1'b0;
            par_acc_q <= 1'b0;
            par_err_q <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            rx_meta_q <= RX;
            rxs_q     <= rx_meta_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            par_en_q  <= par_en_d;
            par_acc_q <= par_acc_d;
            par_err_q <= par_err_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
        end
    end

    assign DATA       = data_q;
    assign VALID      = valid_q;
    assign PARITY_ERR = perr_q;
    assign FRAME_ERR  = ferr_q;
    assign OVERRUN    = ovr_q;
    assign BUSY       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed and randomised frames for uart_rx, checked against a frame-level reference model.
module tb_uart_rx;

    localparam int BT = 40;
    localparam int BIT_CLKS = BT + 1;

    logic       CLK = 1'b0;
    logic       RESET_N;
    logic       RX;
    logic       PARITY_EN;
    logic       PARITY_ODD;
    logic       READ;
    logic [7:0] DATA;
    logic       VALID;
    logic       PARITY_ERR;
    logic       FRAME_ERR;
    logic       OVERRUN;
    logic       BUSY;

    int errs = 0;
    int checks = 0;
    int lat;

    uart_rx #(.BIT_TIME(BT)) dut (
        .CLK(CLK),
        .RESET_N(RESET_N),
        .RX(RX),
        .PARITY_EN(PARITY_EN),
        .PARITY_ODD(PARITY_ODD),
        .READ(READ),
        .DATA(DATA),
        .VALID(VALID),
        .PARITY_ERR(PARITY_ERR),
        .FRAME_ERR(FRAME_ERR),
        .OVERRUN(OVERRUN),
        .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errs++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Parity bit that makes the total count of ones odd (odd=1) or even (odd=0).
    function automatic logic good_pbit(input logic [7:0] d, input logic odd);
        int ones;
        ones = $countones(d);
        return odd ? ((ones % 2) == 0) : ((ones % 2) == 1);
    endfunction

    task automatic drive_bit(input logic b);
        RX = b;
        repeat (BIT_CLKS) @(negedge CLK);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pen, input logic pbit,
                              input int stop_low);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (pen) drive_bit(pbit);
        if (stop_low > 0) begin
            RX = 1'b0;
            repeat (stop_low * BIT_CLKS) @(negedge CLK);
            RX = 1'b1;
        end else begin
            drive_bit(1'b1);
        end
    endtask

    task automatic check_frame(input string tag, input logic [7:0] d, input logic pe,
                               input logic fe, input logic ov);
        chk({tag, ".valid"}, VALID, 1);
        chk({tag, ".data"}, DATA, d);
        chk({tag, ".perr"}, PARITY_ERR, pe);
        chk({tag, ".ferr"}, FRAME_ERR, fe);
        chk({tag, ".ovr"}, OVERRUN, ov);
    endtask

    task automatic ack();
        READ = 1'b1;
        @(negedge CLK);
        READ = 1'b0;
    endtask

    initial begin
        logic [7:0] b;
        logic       pen, podd, pbit, pe;

        RESET_N    = 1'b0;
        RX         = 1'b1;
        READ       = 1'b0;
        PARITY_EN  = 1'b0;
        PARITY_ODD = 1'b0;
        repeat (3) @(negedge CLK);
        RESET_N = 1'b1;
        repeat (3) @(negedge CLK);
        chk("rst.data", DATA, 0);
        chk("rst.valid", VALID, 0);
        chk("rst.perr", PARITY_ERR, 0);
        chk("rst.ferr", FRAME_ERR, 0);
        chk("rst.ovr", OVERRUN, 0);
        chk("rst.busy", BUSY, 0);

        // 0xA5 without parity, measuring falling edge to VALID latency
        lat = 0;
        fork
            send_frame(8'hA5, 1'b0, 1'b0, 0);
            begin
                while (VALID !== 1'b1 && lat < 600) begin
                    @(posedge CLK);
                    #1;
                    lat++;
                end
            end
        join
        chk("a5.latency", lat, 2 + 1 + BT / 2 + 1 + 9 * BIT_CLKS);
        check_frame("a5", 8'hA5, 1'b0, 1'b0, 1'b0);
        ack();
        chk("a5.read_clears", VALID, 0);

        // Odd parity on 0x03: good parity bit then a corrupted one
        PARITY_EN  = 1'b1;
        PARITY_ODD = 1'b1;
        send_frame(8'h03, 1'b1, 1'b1, 0);
        check_frame("par_ok", 8'h03, 1'b0, 1'b0, 1'b0);
        ack();
        send_frame(8'h03, 1'b1, 1'b0, 0);
        check_frame("par_bad", 8'h03, 1'b1, 1'b0, 1'b0);
        ack();

        // Short low glitch must be rejected as a false start
        RX = 1'b0;
        repeat (10) @(negedge CLK);
        chk("glitch.busy_in", BUSY, 1);
        RX = 1'b1;
        repeat (40) @(negedge CLK);
        chk("glitch.busy_out", BUSY, 0);
        chk("glitch.valid", VALID, 0);
        chk("glitch.data", DATA, 8'h03);
        chk("glitch.perr_kept", PARITY_ERR, 1);
        PARITY_EN  = 1'b0;
        PARITY_ODD = 1'b0;
        send_frame(8'h5A, 1'b0, 1'b0, 0);
        check_frame("5a", 8'h5A, 1'b0, 1'b0, 1'b0);
        ack();

        // Break: 0xFF with stop bit held low for three bit times
        send_frame(8'hFF, 1'b0, 1'b0, 3);
        chk("brk.busy_low", BUSY, 1);
        check_frame("brk", 8'hFF, 1'b0, 1'b1, 1'b0);
        repeat (5) @(negedge CLK);
        chk("brk.busy_high", BUSY, 0);
        repeat (12 * BIT_CLKS) @(negedge CLK);
        check_frame("brk.no_second", 8'hFF, 1'b0, 1'b1, 1'b0);
        ack();

        // Overrun: two frames without READ
        send_frame(8'h11, 1'b0, 1'b0, 0);
        @(negedge CLK);
        send_frame(8'h22, 1'b0, 1'b0, 0);
        check_frame("ovr", 8'h22, 1'b0, 1'b0, 1'b1);
        ack();
        chk("ovr.valid_clr", VALID, 0);
        chk("ovr.ovr_clr", OVERRUN, 0);

        // READ on the exact delivery edge while the previous byte is still unread
        send_frame(8'h77, 1'b0, 1'b0, 0);
        @(negedge CLK);
        fork
            send_frame(8'h88, 1'b0, 1'b0, 0);
            begin
                repeat (2 + 1 + BT / 2 + 1 + 9 * BIT_CLKS - 1) @(posedge CLK);
                @(negedge CLK);
                READ = 1'b1;
                @(negedge CLK);
                READ = 1'b0;
            end
        join
        check_frame("rd_on_dlv", 8'h88, 1'b0, 1'b0, 1'b0);
        ack();

        // Random loopback in off/even/odd parity modes, with mid-frame config toggling
        for (int m = 0; m < 3; m++) begin
            pen  = (m != 0);
            podd = (m == 2);
            PARITY_EN  = pen;
            PARITY_ODD = podd;
            for (int k = 0; k < 16; k++) begin
                b    = 8'($urandom_range(0, 255));
                pbit = good_pbit(b, podd);
                if (pen && (k % 5) == 4) pbit = ~pbit;
                pe = pen && (pbit != good_pbit(b, podd));
                fork
                    send_frame(b, pen, pbit, 0);
                    begin
                        repeat (60 + 20 * (k % 4)) @(negedge CLK);
                        PARITY_EN  = ~pen;
                        PARITY_ODD = ~podd;
                    end
                join
                PARITY_EN  = pen;
                PARITY_ODD = podd;
                check_frame($sformatf("rnd%0d_%0d", m, k), b, pe, 1'b0, 1'b0);
                ack();
            end
        end
        PARITY_EN  = 1'b0;
        PARITY_ODD = 1'b0;

        // Asynchronous reset mid-frame with unread, overrun state held
        send_frame(8'h3C, 1'b0, 1'b0, 0);
        @(negedge CLK);
        send_frame(8'h3C, 1'b0, 1'b0, 0);
        chk("pre_rst.ovr", OVERRUN, 1);
        RX = 1'b0;
        repeat (200) @(negedge CLK);
        chk("mid.busy", BUSY, 1);
        RESET_N = 1'b0;
        #1;
        chk("mid_rst.data", DATA, 0);
        chk("mid_rst.valid", VALID, 0);
        chk("mid_rst.perr", PARITY_ERR, 0);
        chk("mid_rst.ferr", FRAME_ERR, 0);
        chk("mid_rst.ovr", OVERRUN, 0);
        chk("mid_rst.busy", BUSY, 0);
        RX = 1'b1;
        @(negedge CLK);
        RESET_N = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge CLK);
        chk("post_rst.valid", VALID, 0);
        send_frame(8'hC3, 1'b0, 1'b0, 0);
        check_frame("post_rst", 8'hC3, 1'b0, 1'b0, 1'b0);
        ack();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
